// File: rtl/mau_pkg.sv
// Shared types for the memory access unit: access sizes, FSM states and the
// alignment/legality check applied when a request is accepted.
package mau_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACCESS = 2'b01,
    S_RESP   = 2'b10
  } state_e;

  // 1 when the access cannot be issued: misaligned, or a doubleword on a 32-bit unit
  function automatic logic misaligned(input size_e sz, input logic [2:0] lo, input int xlen);
    case (sz)
      SZ_B:    return 1'b0;
      SZ_H:    return lo[0];
      SZ_W:    return |lo[1:0];
      default: return (xlen == 32) || (|lo);
    endcase
  endfunction

endpackage

// File: rtl/mau_if.sv
// Core-side request/response and memory-port signals of the memory access unit.
// slave = the unit itself, master = the core/memory environment around it.
interface mau_if #(parameter int XLEN = 32);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [XLEN-1:0]   req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              rsp_valid;
  logic [XLEN-1:0]   rsp_rdata;
  logic              rsp_err;
  logic              busy;
  logic              mem_req;
  logic              mem_we;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN/8-1:0] mem_be;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_ack;
  logic [XLEN-1:0]   mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  mem_ack, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output mem_ack, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

endinterface

// File: rtl/mau_lane_align.sv
// Byte-lane steering: store byte enables and replicated write data, and
// extraction plus sign/zero extension of the addressed lane of a load word.
module mau_lane_align
  import mau_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  size_e                     size,
  input  logic [$clog2(XLEN/8)-1:0] offset,
  input  logic                      is_unsigned,
  input  logic [XLEN-1:0]           st_data,
  input  logic [XLEN-1:0]           ld_word,
  output logic [XLEN/8-1:0]         be,
  output logic [XLEN-1:0]           st_lane,
  output logic [XLEN-1:0]           ld_data
);

  localparam int NB = XLEN / 8;

  int              nbytes;
  logic [NB-1:0]   size_mask;
  logic [XLEN-1:0] byte_mask;
  logic [XLEN-1:0] shifted;
  logic            sign_bit;

  always_comb begin
    nbytes    = 1 << size;
    size_mask = '0;
    byte_mask = '0;
    st_lane   = '0;
    for (int i = 0; i < NB; i++) begin
      size_mask[i]         = (i < nbytes);
      byte_mask[8*i +: 8]  = {8{size_mask[i]}};
      // low nbytes of the store data repeat across every lane
      st_lane[8*i +: 8]    = st_data[8*(i & (nbytes - 1)) +: 8];
    end
    be      = size_mask << offset;
    shifted = ld_word >> {offset, 3'b000};
    case (size)
      SZ_B:    sign_bit = shifted[7];
      SZ_H:    sign_bit = shifted[15];
      SZ_W:    sign_bit = shifted[31];
      default: sign_bit = shifted[XLEN-1];
    endcase
    ld_data = shifted & byte_mask;
    if (!is_unsigned && sign_bit) begin
      ld_data = ld_data | ~byte_mask;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store unit with a valid/ready core handshake and a stalling memory port.
// Optional MAU_TIMEOUT_EN: abort an access after TIMEOUT_CYCLES cycles without mem_ack.
//   state    | meaning
//   S_IDLE   | ready for a request
//   S_ACCESS | memory request outstanding, waiting for mem_ack
//   S_RESP   | one-cycle response (data or error)
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic  clk,
  input logic  reset,
  mau_if.slave bus
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  state_e          state_q, state_d;
  logic            we_q, we_d;
  size_e           size_q, size_d;
  logic            uns_q, uns_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;

  logic [NB-1:0]   lane_be;
  logic [XLEN-1:0] lane_wdata;
  logic [XLEN-1:0] lane_load;
  logic            timeout_hit;
  logic            in_access;

  assign in_access = (state_q == S_ACCESS);

  mau_lane_align #(.XLEN(XLEN)) u_lane_align (
    .size        (size_q),
    .offset      (addr_q[OFFW-1:0]),
    .is_unsigned (uns_q),
    .st_data     (wdata_q),
    .ld_word     (bus.mem_rdata),
    .be          (lane_be),
    .st_lane     (lane_wdata),
    .ld_data     (lane_load)
  );

`ifdef MAU_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? 16 : 8;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Reloaded while idle so the first ACCESS cycle starts at TIMEOUT_CYCLES-1
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_IDLE) begin
      cnt_d = CNT_W'(TIMEOUT_CYCLES - 1);
    end else if (in_access && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign timeout_hit = in_access && (cnt_q == '0);
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          size_d  = size_e'(bus.req_size);
          uns_d   = bus.req_unsigned;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          rdata_d = '0;
          err_d   = misaligned(size_e'(bus.req_size), bus.req_addr[2:0], XLEN);
          state_d = err_d ? S_RESP : S_ACCESS;
        end
      end
      S_ACCESS: begin
        // an ack on the last allowed cycle still completes the access
        if (bus.mem_ack) begin
          rdata_d = we_q ? '0 : lane_load;
          state_d = S_RESP;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.mem_req   = in_access;
  assign bus.mem_we    = in_access && we_q;
  assign bus.mem_addr  = in_access ? {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}} : '0;
  assign bus.mem_be    = in_access ? lane_be : '0;
  assign bus.mem_wdata = (in_access && we_q) ? lane_wdata : '0;
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_err   = (state_q == S_RESP) && err_q;
  assign bus.rsp_rdata = (state_q == S_RESP) ? rdata_q : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: 32-bit and 64-bit instances, directed table plus
// random transactions checked against an arithmetic reference model.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mau_if #(.XLEN(32)) if32 ();
  mau_if #(.XLEN(64)) if64 ();

  mem_access_unit #(.XLEN(32), .TIMEOUT_CYCLES(4)) u_dut32 (
    .clk   (clk),
    .reset (reset),
    .bus   (if32)
  );

  mem_access_unit #(.XLEN(64), .TIMEOUT_CYCLES(255)) u_dut64 (
    .clk   (clk),
    .reset (reset),
    .bus   (if64)
  );

  typedef struct {
    logic        err;
    logic [7:0]  be;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
  } exp_t;

  typedef struct {
    int          xl;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    int          waits;
    exp_t        exp;
  } vec_t;

  typedef struct {
    logic        ready;
    logic        busy;
    logic        rsp_valid;
    logic        rsp_err;
    logic [63:0] rsp_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [7:0]  mem_be;
    logic [63:0] mem_wdata;
  } obs_t;

  int    n_vec = 0;
  int    n_err = 0;
  string tag;
  vec_t  tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL [%s] %s: got %0h, expected %0h", tag, name, act, exp);
    end
  endtask

  // Reference: derived from the size/offset rules with plain integer arithmetic
  function automatic exp_t model(input int xl, input logic we, input logic [1:0] size,
                                 input logic uns, input logic [63:0] addr,
                                 input logic [63:0] wdata, input logic [63:0] rdata);
    exp_t        e;
    int          nb;
    int          wb;
    int          off;
    logic [63:0] vmask;
    logic [63:0] rep;
    logic [63:0] v;
    nb    = 1 << size;
    wb    = xl / 8;
    e.err = ((size == 2'd3) && (xl == 32)) || ((addr % nb) != 0);
    off   = int'(addr % wb);
    vmask = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
    rep   = '0;
    for (int k = 0; k < wb; k += nb) rep = rep | ((wdata & vmask) << (8 * k));
    v = (rdata >> (8 * off)) & vmask;
    if (!uns && v[8*nb-1]) v = v | ~vmask;
    if (xl == 32) v = v & 64'hFFFF_FFFF;
    e.addr  = e.err ? 64'd0 : (addr - 64'(off));
    e.be    = e.err ? 8'd0 : 8'(((1 << nb) - 1) << off);
    e.wdata = (e.err || !we) ? 64'd0 : rep;
    e.rdata = (e.err || we) ? 64'd0 : v;
    return e;
  endfunction

  function automatic vec_t mk(input int xl, input logic we, input logic [1:0] size,
                              input logic uns, input logic [63:0] addr, input logic [63:0] wdata,
                              input logic [63:0] rdata, input int waits, input logic e_err,
                              input logic [7:0] e_be, input logic [63:0] e_addr,
                              input logic [63:0] e_wdata, input logic [63:0] e_rdata);
    vec_t v;
    v.xl = xl; v.we = we; v.size = size; v.uns = uns;
    v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.waits = waits;
    v.exp.err = e_err; v.exp.be = e_be; v.exp.addr = e_addr;
    v.exp.wdata = e_wdata; v.exp.rdata = e_rdata;
    return v;
  endfunction

  function automatic obs_t sample(input int xl);
    obs_t o;
    if (xl == 32) begin
      o.ready = if32.req_ready; o.busy = if32.busy;
      o.rsp_valid = if32.rsp_valid; o.rsp_err = if32.rsp_err;
      o.rsp_rdata = 64'(if32.rsp_rdata); o.mem_req = if32.mem_req; o.mem_we = if32.mem_we;
      o.mem_addr = 64'(if32.mem_addr); o.mem_be = 8'(if32.mem_be);
      o.mem_wdata = 64'(if32.mem_wdata);
    end else begin
      o.ready = if64.req_ready; o.busy = if64.busy;
      o.rsp_valid = if64.rsp_valid; o.rsp_err = if64.rsp_err;
      o.rsp_rdata = if64.rsp_rdata; o.mem_req = if64.mem_req; o.mem_we = if64.mem_we;
      o.mem_addr = if64.mem_addr; o.mem_be = if64.mem_be; o.mem_wdata = if64.mem_wdata;
    end
    return o;
  endfunction

  task automatic drive_req(input logic valid, input vec_t v);
    if (v.xl == 32) begin
      if32.req_valid = valid; if32.req_we = v.we; if32.req_size = v.size;
      if32.req_unsigned = v.uns; if32.req_addr = v.addr[31:0]; if32.req_wdata = v.wdata[31:0];
    end else begin
      if64.req_valid = valid; if64.req_we = v.we; if64.req_size = v.size;
      if64.req_unsigned = v.uns; if64.req_addr = v.addr; if64.req_wdata = v.wdata;
    end
  endtask

  task automatic set_ack(input int xl, input logic ack, input logic [63:0] rdata);
    if (xl == 32) begin
      if32.mem_ack = ack; if32.mem_rdata = rdata[31:0];
    end else begin
      if64.mem_ack = ack; if64.mem_rdata = rdata;
    end
  endtask

  // Called #1 after a rising edge; returns at the same phase one cycle after the response
  task automatic run_txn(input vec_t v);
    obs_t o;
    drive_req(1'b1, v);
    o = sample(v.xl);
    check("ready_before_accept", o.ready, 1);
    @(posedge clk); #1;
    drive_req(1'b0, v);
    if (v.exp.err) begin
      o = sample(v.xl);
      check("err_rsp_valid", o.rsp_valid, 1);
      check("err_rsp_err", o.rsp_err, 1);
      check("err_rsp_rdata", o.rsp_rdata, 0);
      check("err_no_mem_req", o.mem_req, 0);
    end else begin
      for (int w = 0; w <= v.waits; w++) begin
        o = sample(v.xl);
        check("mem_req", o.mem_req, 1);
        check("mem_addr", o.mem_addr, v.exp.addr);
        check("mem_be", o.mem_be, v.exp.be);
        check("mem_we", o.mem_we, v.we);
        check("mem_wdata", o.mem_wdata, v.exp.wdata);
        check("no_early_rsp", o.rsp_valid, 0);
        check("ready_low_access", o.ready, 0);
        set_ack(v.xl, w == v.waits, (w == v.waits) ? v.rdata : {$urandom, $urandom});
        @(posedge clk); #1;
        set_ack(v.xl, 1'b0, 64'd0);
      end
      o = sample(v.xl);
      check("rsp_valid", o.rsp_valid, 1);
      check("rsp_err", o.rsp_err, 0);
      check("rsp_rdata", o.rsp_rdata, v.exp.rdata);
      check("mem_req_dropped", o.mem_req, 0);
      check("busy_resp", o.busy, 1);
    end
    @(posedge clk); #1;
    o = sample(v.xl);
    check("rsp_one_cycle", o.rsp_valid, 0);
    check("ready_after", o.ready, 1);
    check("busy_after", o.busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t o;
    vec_t v;

    if32.req_valid = 0; if32.req_we = 0; if32.req_size = 0; if32.req_unsigned = 0;
    if32.req_addr = 0; if32.req_wdata = 0; if32.mem_ack = 0; if32.mem_rdata = 0;
    if64.req_valid = 0; if64.req_we = 0; if64.req_size = 0; if64.req_unsigned = 0;
    if64.req_addr = 0; if64.req_wdata = 0; if64.mem_ack = 0; if64.mem_rdata = 0;

    repeat (3) @(posedge clk);
    #1;
    tag = "reset";
    for (int x = 32; x <= 64; x += 32) begin
      o = sample(x);
      check("rst_ready", o.ready, 1);
      check("rst_busy", o.busy, 0);
      check("rst_mem_req", o.mem_req, 0);
      check("rst_rsp_valid", o.rsp_valid, 0);
      check("rst_mem_be", o.mem_be, 0);
    end
    reset = 1'b1;

    // xl, we, size, uns, addr, wdata, rdata, waits | err, be, mem_addr, mem_wdata, rsp_rdata
    tbl.push_back(mk(32, 0, 0, 0, 64'h103, 0, 64'h80FF_0000, 0, 0, 8'b1000, 64'h100, 0, 64'hFFFF_FF80));
    tbl.push_back(mk(32, 0, 1, 1, 64'h102, 0, 64'h8001_1234, 0, 0, 8'b1100, 64'h100, 0, 64'h0000_8001));
    tbl.push_back(mk(32, 1, 0, 0, 64'h101, 64'hAB, 64'hDEAD_BEEF, 1, 0, 8'b0010, 64'h100, 64'hABAB_ABAB, 0));
    tbl.push_back(mk(32, 0, 2, 0, 64'h102, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(32, 0, 3, 0, 64'h100, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(32, 1, 1, 0, 64'h102, 64'h1234_BEEF, 0, 2, 0, 8'b1100, 64'h100, 64'hBEEF_BEEF, 0));
    tbl.push_back(mk(32, 0, 1, 0, 64'h0, 0, 64'h0000_8001, 0, 0, 8'b0011, 64'h0, 0, 64'hFFFF_8001));
    tbl.push_back(mk(64, 0, 3, 0, 64'h8, 0, 64'h1122_3344_5566_7788, 0, 0, 8'hFF, 64'h8, 0, 64'h1122_3344_5566_7788));
    tbl.push_back(mk(64, 0, 0, 0, 64'h7, 0, 64'hF100_0000_0000_0000, 1, 0, 8'h80, 64'h0, 0, 64'hFFFF_FFFF_FFFF_FFF1));
    tbl.push_back(mk(64, 0, 2, 1, 64'h4, 0, 64'h9ABC_DEF0_1234_5678, 0, 0, 8'hF0, 64'h0, 0, 64'h0000_0000_9ABC_DEF0));
    tbl.push_back(mk(64, 0, 2, 0, 64'hC, 0, 64'h9ABC_DEF0_1234_5678, 0, 0, 8'hF0, 64'h8, 0, 64'hFFFF_FFFF_9ABC_DEF0));
    tbl.push_back(mk(64, 1, 2, 0, 64'h14, 64'hCAFE_F00D, 0, 3, 0, 8'hF0, 64'h10, 64'hCAFE_F00D_CAFE_F00D, 0));
    tbl.push_back(mk(64, 0, 1, 0, 64'h3, 0, 0, 0, 1, 0, 0, 0, 0));

    for (int n = 0; n < 60; n++) begin
      v.xl    = ($urandom_range(0, 1) != 0) ? 64 : 32;
      v.we    = 1'($urandom_range(0, 1));
      v.size  = 2'($urandom_range(0, 3));
      v.uns   = 1'($urandom_range(0, 1));
      v.addr  = {$urandom, $urandom};
      v.wdata = {$urandom, $urandom};
      v.rdata = {$urandom, $urandom};
      if (v.xl == 32) begin
        v.addr[63:32] = '0; v.wdata[63:32] = '0; v.rdata[63:32] = '0;
      end
      if ($urandom_range(0, 3) != 0) v.addr = v.addr & ~((64'd1 << v.size) - 64'd1);
      v.waits = $urandom_range(0, 3);
      v.exp   = model(v.xl, v.we, v.size, v.uns, v.addr, v.wdata, v.rdata);
      tbl.push_back(v);
    end

    foreach (tbl[i]) begin
      tag = $sformatf("vec%0d/x%0d", i, tbl[i].xl);
      run_txn(tbl[i]);
    end

    // mem_ack while idle must not produce a response
    tag = "ack_idle";
    set_ack(32, 1'b1, 64'h1234_5678);
    repeat (2) begin
      @(posedge clk); #1;
      o = sample(32);
      check("idle_ack_rsp", o.rsp_valid, 0);
      check("idle_ack_busy", o.busy, 0);
    end
    set_ack(32, 1'b0, 64'd0);

    // reset during ACCESS, then a late ack in IDLE
    tag = "reset_mid";
    v = mk(32, 0, 2, 0, 64'h200, 0, 0, 0, 0, 0, 0, 0, 0);
    drive_req(1'b1, v);
    @(posedge clk); #1;
    drive_req(1'b0, v);
    o = sample(32);
    check("mid_mem_req", o.mem_req, 1);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    set_ack(32, 1'b1, 64'hCAFE_BABE);
    o = sample(32);
    check("mid_mem_req_drop", o.mem_req, 0);
    check("mid_ready", o.ready, 1);
    check("mid_busy", o.busy, 0);
    @(posedge clk); #1;
    set_ack(32, 1'b0, 64'd0);
    o = sample(32);
    check("mid_no_rsp", o.rsp_valid, 0);
    check("mid_still_idle", o.ready, 1);

`ifdef MAU_TIMEOUT_EN
    tag = "timeout";
    v = mk(32, 0, 2, 0, 64'h300, 0, 0, 0, 0, 0, 0, 0, 0);
    drive_req(1'b1, v);
    @(posedge clk); #1;
    drive_req(1'b0, v);
    for (int c = 0; c < 4; c++) begin
      o = sample(32);
      check("to_mem_req", o.mem_req, 1);
      check("to_no_rsp", o.rsp_valid, 0);
      @(posedge clk); #1;
    end
    o = sample(32);
    check("to_rsp_valid", o.rsp_valid, 1);
    check("to_rsp_err", o.rsp_err, 1);
    check("to_rsp_rdata", o.rsp_rdata, 0);
    check("to_mem_req_drop", o.mem_req, 0);
    @(posedge clk); #1;
    o = sample(32);
    check("to_ready", o.ready, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
